writeback_stage: RTL

Final stage of the pipelined RISC-V core, directly downstream of the memory stage. It holds the MEM/WB pipeline register and pairs each instruction's control with the load data that the memory stage returns one clock after the address. It extracts and sign- or zero-extends sub-word loads, selects the register-file write value and drives the single register-file write port, which is also the WB forwarding source. It also detects misaligned or unsupported loads.

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/load_align.sv | 63 ++++++
 rtl/writeback_stage.sv | 136 +++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core pipeline: load funct3 codes,
// write-back source select encoding and default datapath widths.
package riscv_pkg;

    localparam int DATA_WIDTH_DEF     = 32;
    localparam int REG_ADDR_WIDTH_DEF = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        WB_SEL_ALU = 2'd0,
        WB_SEL_MEM = 2'd1,
        WB_SEL_PC4 = 2'd2
    } wb_sel_e;

    // Link value wins over load data, which wins over the ALU result.
    function automatic wb_sel_e wb_select(input logic jump, input logic mem_read);
        if (jump)
            return WB_SEL_PC4;
        else if (mem_read)
            return WB_SEL_MEM;
        else
            return WB_SEL_ALU;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks the byte/half lane addressed by addr[1:0],
// sign- or zero-extends it, and flags misaligned or unsupported loads.
module load_align
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic [2:0]            funct3,
    input  logic [1:0]            addr,
    input  logic [DATA_WIDTH-1:0] raw_data,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  fault
);

    function automatic logic signed [DATA_WIDTH-1:0] sext8(input logic signed [7:0] b);
        logic signed [DATA_WIDTH-1:0] r;
        r = b;
        return r;
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] sext16(input logic signed [15:0] h);
        logic signed [DATA_WIDTH-1:0] r;
        r = h;
        return r;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] zext8(input logic [7:0] b);
        return {{(DATA_WIDTH-8){1'b0}}, b};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] zext16(input logic [15:0] h);
        return {{(DATA_WIDTH-16){1'b0}}, h};
    endfunction

    logic signed [7:0]  byte_lane;
    logic signed [15:0] half_lane;

    // Lane selection, extension and fault detection by load type.
    always_comb begin
        byte_lane = raw_data[{addr, 3'b000} +: 8];
        half_lane = raw_data[{addr[1], 4'b0000} +: 16];
        load_data = raw_data;
        fault     = 1'b0;
        case (funct3)
            F3_LB:  load_data = sext8(byte_lane);
            F3_LBU: load_data = zext8(byte_lane);
            F3_LH: begin
                load_data = sext16(half_lane);
                fault     = addr[0];
            end
            F3_LHU: begin
                load_data = zext16(half_lane);
                fault     = addr[0];
            end
            F3_LW: begin
                load_data = raw_data;
                fault     = (addr != 2'b00);
            end
            default: fault = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Write-back stage: MEM/WB pipeline register, load data capture/hold,
// register-file write port and load fault detection.
// Optional feature macro WB_RETIRE_CNT_EN adds the retire_count output
// and a CNT_WIDTH-bit retired-instruction counter.
module writeback_stage
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
`ifdef WB_RETIRE_CNT_EN
    ,
    parameter int CNT_WIDTH      = 64
`endif
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      mem_valid,
    input  logic                      mem_reg_write,
    input  logic                      mem_mem_read,
    input  logic                      mem_jump,
    input  logic [2:0]                mem_funct3,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0]     mem_alu_result,
    input  logic [DATA_WIDTH-1:0]     mem_pc_plus4,
    input  logic [DATA_WIDTH-1:0]     read_data,
    output logic                      rf_we,
    output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0]     rf_wdata,
    output logic                      wb_valid,
    output logic                      load_fault
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]      retire_count
`endif
);

    logic                      vld_p1;
    logic                      reg_write_p1;
    logic                      mem_read_p1;
    logic                      jump_p1;
    logic [2:0]                funct3_p1;
    logic [REG_ADDR_WIDTH-1:0] rd_p1;
    logic [DATA_WIDTH-1:0]     alu_result_p1;
    logic [DATA_WIDTH-1:0]     pc_plus4_p1;
    logic                      issued_p1;
    logic [DATA_WIDTH-1:0]     hold_data_p1;

    logic [DATA_WIDTH-1:0]     raw_load;
    logic [DATA_WIDTH-1:0]     aligned_data;
    logic                      align_fault;
    logic                      fault;
    logic                      retire;
    wb_sel_e                   wb_sel;

    // MEM/WB register: flush beats stall, stall holds and marks the slot issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1        <= 1'b0;
            reg_write_p1  <= 1'b0;
            mem_read_p1   <= 1'b0;
            jump_p1       <= 1'b0;
            funct3_p1     <= 3'b000;
            rd_p1         <= '0;
            alu_result_p1 <= '0;
            pc_plus4_p1   <= '0;
            issued_p1     <= 1'b0;
        end else if (flush) begin
            vld_p1        <= 1'b0;
        end else if (stall) begin
            issued_p1     <= 1'b1;
        end else begin
            vld_p1        <= mem_valid;
            reg_write_p1  <= mem_reg_write;
            mem_read_p1   <= mem_mem_read;
            jump_p1       <= mem_jump;
            funct3_p1     <= mem_funct3;
            rd_p1         <= mem_rd;
            alu_result_p1 <= mem_alu_result;
            pc_plus4_p1   <= mem_pc_plus4;
            issued_p1     <= 1'b0;
        end
    end

    // Snapshot the memory output during the first WB cycle so a stalled load
    // keeps its value even if the memory output moves on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hold_data_p1 <= '0;
        else if (!issued_p1)
            hold_data_p1 <= read_data;
    end

    assign raw_load = issued_p1 ? hold_data_p1 : read_data;

    load_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_align (
        .funct3    (funct3_p1),
        .addr      (alu_result_p1[1:0]),
        .raw_data  (raw_load),
        .load_data (aligned_data),
        .fault     (align_fault)
    );

    // Write port, fault pulse and retire qualification for the WB slot.
    always_comb begin
        fault      = mem_read_p1 & align_fault;
        wb_sel     = wb_select(jump_p1, mem_read_p1);
        rf_we      = vld_p1 & reg_write_p1 & (rd_p1 != '0) & ~fault & ~issued_p1;
        load_fault = vld_p1 & mem_read_p1 & fault & ~issued_p1;
        retire     = vld_p1 & ~issued_p1 & ~fault;
        rf_waddr   = rd_p1;
        wb_valid   = vld_p1;
        case (wb_sel)
            WB_SEL_PC4: rf_wdata = pc_plus4_p1;
            WB_SEL_MEM: rf_wdata = aligned_data;
            default:    rf_wdata = alu_result_p1;
        endcase
    end

`ifdef WB_RETIRE_CNT_EN
    // Retired-instruction counter, wraps naturally at its width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retire_count <= '0;
        else if (retire)
            retire_count <= retire_count + CNT_WIDTH'(1);
    end
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

endmodule
